// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Holds EX via stall_request until a registered {remainder, quotient} is ready.
module div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        annul,
  input  logic        signed_div,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall_request
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t      r_state, w_state_next;
  logic [5:0]  r_cnt, w_cnt_next;
  logic [63:0] r_work, w_work_next;       // {partial remainder, quotient}
  logic [31:0] r_divisor, w_divisor_next;
  logic        r_neg_q, w_neg_q_next;
  logic        r_neg_r, w_neg_r_next;
  logic [63:0] r_result, w_result_next;
  logic        r_ready, w_ready_next;

  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [32:0] w_trial;
  logic        w_fits;
  logic [31:0] w_sub;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Magnitudes are taken modulo 2^32, so |0x80000000| stays 0x80000000.
  assign w_mag1 = (signed_div && operand1[31]) ? (32'd0 - operand1) : operand1;
  assign w_mag2 = (signed_div && operand2[31]) ? (32'd0 - operand2) : operand2;

  // Partial remainder after the left shift; it never exceeds 33 bits.
  assign w_trial = r_work[63:31];
  assign w_fits  = (w_trial >= {1'b0, r_divisor});
  assign w_sub   = w_trial[31:0] - r_divisor;

  assign w_quot = r_neg_q ? (32'd0 - r_work[31:0])  : r_work[31:0];
  assign w_rem  = r_neg_r ? (32'd0 - r_work[63:32]) : r_work[63:32];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= FREE;
      r_cnt     <= 6'd0;
      r_work    <= 64'd0;
      r_divisor <= 32'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= 64'd0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_work    <= w_work_next;
      r_divisor <= w_divisor_next;
      r_neg_q   <= w_neg_q_next;
      r_neg_r   <= w_neg_r_next;
      r_result  <= w_result_next;
      r_ready   <= w_ready_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_work_next    = r_work;
    w_divisor_next = r_divisor;
    w_neg_q_next   = r_neg_q;
    w_neg_r_next   = r_neg_r;
    w_result_next  = r_result;
    w_ready_next   = r_ready;

    if (annul) begin
      w_state_next  = FREE;
      w_cnt_next    = 6'd0;
      w_result_next = 64'd0;
      w_ready_next  = 1'b0;
    end else begin
      case (r_state)
        FREE: begin
          w_ready_next = 1'b0;
          if (start) begin
            if (operand2 == 32'd0) begin
              w_state_next = BY_ZERO;
            end else begin
              w_state_next   = ON;
              w_cnt_next     = 6'd0;
              w_work_next    = {32'd0, w_mag1};
              w_divisor_next = w_mag2;
              w_neg_q_next   = signed_div & (operand1[31] ^ operand2[31]);
              w_neg_r_next   = signed_div & operand1[31];
            end
          end
        end

        BY_ZERO: begin
          w_state_next  = END;
          w_result_next = 64'd0;
          w_ready_next  = 1'b1;
        end

        ON: begin
          if (!start) begin
            w_state_next = FREE;
            w_ready_next = 1'b0;
          end else if (r_cnt == 6'd32) begin
            w_state_next  = END;
            w_result_next = {w_rem, w_quot};
            w_ready_next  = 1'b1;
          end else begin
            // One restoring step: keep the difference only if it is non-negative.
            if (w_fits) begin
              w_work_next = {w_sub, r_work[30:0], 1'b1};
            end else begin
              w_work_next = {r_work[62:0], 1'b0};
            end
            w_cnt_next = r_cnt + 6'd1;
          end
        end

        END: begin
          w_ready_next = 1'b1;
          if (!start) begin
            w_state_next = FREE;
            w_ready_next = 1'b0;
          end
        end

        default: begin
          w_state_next = FREE;
          w_ready_next = 1'b0;
        end
      endcase
    end
  end

  assign result        = r_result;
  assign ready         = r_ready;
  assign stall_request = start & ~r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Randomized scoreboard bench for div_unit: the driver queues reference results,
// a negedge monitor pops one whenever ready rises.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [63:0] result;
  logic        ready;
  logic        stall_request;

  int vectors    = 0;
  int miscompares = 0;

  logic [63:0] exp_q[$];
  logic        ready_q = 1'b0;

  div_unit dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .annul         (annul),
    .signed_div    (signed_div),
    .operand1      (operand1),
    .operand2      (operand2),
    .result        (result),
    .ready         (ready),
    .stall_request (stall_request)
  );

  always #5 clock = ~clock;

  // Reference: plain integer division, truncating toward zero in signed mode.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint      sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare the result against the oldest outstanding expectation.
  always @(negedge clock) begin
    if (ready && !ready_q) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ready: got result %h, expected no ready", result);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result", result, e);
        $display("div result=%h expected=%h", result, e);
      end
    end
    ready_q <= ready;
  end

  // Issue one divide from a post-edge point, hold start until ready, then release.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit scramble);
    int cyc;
    int stalls;
    int exp_lat;
    bit done;
    exp_lat    = (b == 32'd0) ? 2 : 34;
    operand1   = a;
    operand2   = b;
    signed_div = s;
    start      = 1'b1;
    exp_q.push_back(ref_div(a, b, s));
    cyc    = 0;
    stalls = 0;
    done   = 1'b0;
    while (!done && cyc < 80) begin
      @(negedge clock);
      if (stall_request) stalls++;
      if (ready) begin
        done = 1'b1;
      end else begin
        cyc++;
        if (scramble && cyc > 1) begin
          operand1 = $urandom;
          operand2 = $urandom;
        end
      end
    end
    if (!done && exp_q.size() != 0) void'(exp_q.pop_back());
    check("latency", 64'(cyc), 64'(exp_lat));
    check("stall_cycles", 64'(stalls), 64'(exp_lat));
    @(posedge clock); #1;
    start    = 1'b0;
    operand1 = $urandom;
    operand2 = $urandom;
    @(posedge clock); #1;
    check("ready_drop", 64'(ready), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    reset      = 1'b1;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    operand1   = 32'd0;
    operand2   = 32'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_stall", 64'(stall_request), 64'd0);
    @(posedge clock); #1;

    // Directed cases
    do_div(32'd100, 32'd7, 1'b0, 1'b0);
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    do_div(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_div(32'd12345, 32'd0, 1'b1, 1'b0);
    do_div(32'd0, 32'd5, 1'b1, 1'b0);
    do_div(32'hDEADBEEF, 32'h00001234, 1'b0, 1'b1);
    do_div(32'h8000BEEF, 32'h00000013, 1'b1, 1'b1);

    // Annul mid-operation clears the held result
    do_div(32'd100, 32'd7, 1'b0, 1'b0);
    operand1   = 32'd100;
    operand2   = 32'd7;
    signed_div = 1'b0;
    start      = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("held_result", result, {32'd2, 32'd14});
    annul = 1'b1;
    @(posedge clock); #1;
    annul = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("annul_ready", 64'(ready), 64'd0);
    check("annul_result", result, 64'd0);
    @(posedge clock); #1;
    do_div(32'd100, 32'd7, 1'b0, 1'b0);

    // Start coinciding with annul is not accepted: full latency counts from the next cycle
    operand1 = 32'd999;
    operand2 = 32'd10;
    start    = 1'b1;
    annul    = 1'b1;
    @(posedge clock); #1;
    annul = 1'b0;
    do_div(32'd999, 32'd10, 1'b0, 1'b0);

    // Synchronous reset in the middle of a divide
    operand1   = 32'h12345678;
    operand2   = 32'd3;
    signed_div = 1'b0;
    start      = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    reset = 1'b1;
    start = 1'b0;
    @(posedge clock); #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_stall", 64'(stall_request), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Randomized divides with occasional corner divisors
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = $urandom_range(1, 15);
        3:       a = 32'h80000000;
        default: b = $urandom;
      endcase
      if (b == 32'd0 && $urandom_range(0, 3) != 0) b = 32'd1 + {28'd0, 4'($urandom)};
      do_div(a, b, 1'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clock);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending: got %0d outstanding results, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
